conversion_sequencer: RTL and testbench

CONVERSION_SEQUENCER -- requirements
Module: conversion_sequencer

---
 rtl/conversion_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_conversion_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conversion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conversion_sequencer
// Description : Run controller for a delta-sigma modulator and its decimation
//               filter. Supports incremental conversions (clear, integrate for
//               osr_eff cycles, dump, capture) and regular free-running
//               conversions (capture every DEC_M cycles once the filter has
//               settled). Captured results are offered on a valid/ready
//               holding register with a sticky overrun flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   start, stop         : run request (IDLE only) / abort (any busy state)
//   continuous, mode    : repeat-until-stop select, 0=incremental 1=regular
//   osr                 : incremental conversion length, clamped to >= 2
//   filt_z              : filter output sampled on capture
//   filt_rst            : registered filter dump strobe
//   filt_type           : registered filter type (latched mode)
//   filt_greset         : registered filter global clear
//   busy                : high in every state except IDLE
//   result/result_valid : captured result and its valid flag
//   result_ready        : consumer handshake
//   overrun             : sticky, a capture was dropped for lack of space
// ============================================================================
module conversion_sequencer #(
  parameter int OUTPUT_BITS = 16,
  parameter int OSR_BITS    = 8,
  parameter int DEC_M       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic                   mode,
  input  logic [OSR_BITS-1:0]    osr,
  input  logic [OUTPUT_BITS-1:0] filt_z,
  output logic                   filt_rst,
  output logic                   filt_type,
  output logic                   filt_greset,
  output logic                   busy,
  output logic [OUTPUT_BITS-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);

  localparam int DEC_BITS = (DEC_M > 1) ? $clog2(DEC_M) : 1;
  localparam int CNT_BITS = (OSR_BITS > DEC_BITS) ? OSR_BITS : DEC_BITS;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] DEC_LAST = CNT_BITS'(DEC_M - 1);
  localparam logic [OSR_BITS-1:0] OSR_MIN  = OSR_BITS'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    INTEG   = 3'd2,
    DUMP    = 3'd3,
    CAPTURE = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [CNT_BITS-1:0] count, count_next;
  logic [CNT_BITS-1:0] osr_last;      // latched osr_eff - 1
  logic                cont_lat;
  // Completed regular-mode periods since CLEAR, saturating at 2. The sample
  // closing the first period is still polluted by the filter's start-up.
  logic [1:0]          periods, periods_next;
  logic                capture;
  logic                accept_start;
  logic [OSR_BITS-1:0] osr_clamped;

  assign osr_clamped = (osr < OSR_MIN) ? OSR_MIN : osr;
  assign busy        = (state != IDLE);

  always_comb begin
    state_next   = state;
    count_next   = count;
    periods_next = periods;
    capture      = 1'b0;
    accept_start = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          accept_start = 1'b1;
          state_next   = CLEAR;
        end
      end
      CLEAR: begin
        count_next   = '0;
        periods_next = 2'd0;
        state_next   = INTEG;
      end
      INTEG: begin
        if (!filt_type) begin
          if (count == osr_last) begin
            state_next = DUMP;
          end else begin
            count_next = count + CNT_ONE;
          end
        end else begin
          if ((count == '0) && (periods == 2'd2)) begin
            capture = 1'b1;
          end
          if (count == DEC_LAST) begin
            count_next = '0;
            if (periods != 2'd2) begin
              periods_next = periods + 2'd1;
            end
          end else begin
            count_next = count + CNT_ONE;
          end
        end
      end
      DUMP: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        count_next = '0;
        state_next = cont_lat ? INTEG : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort overrides everything, including a capture due this cycle.
    if (stop && (state != IDLE)) begin
      state_next = IDLE;
      count_next = '0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      periods      <= 2'd0;
      osr_last     <= '0;
      cont_lat     <= 1'b0;
      filt_rst     <= 1'b0;
      filt_type    <= 1'b0;
      filt_greset  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      periods     <= periods_next;
      // Strobes are registered from the next state so they line up exactly
      // with the CLEAR / DUMP cycles and vanish when a stop pre-empts them.
      filt_greset <= (state_next == CLEAR);
      filt_rst    <= (state_next == DUMP);
      if (accept_start) begin
        filt_type <= mode;
        cont_lat  <= continuous;
        osr_last  <= CNT_BITS'(osr_clamped) - CNT_ONE;
      end
      if (capture && (!result_valid || result_ready)) begin
        result       <= filt_z;
        result_valid <= 1'b1;
      end else begin
        if (result_valid && result_ready) begin
          result_valid <= 1'b0;
        end
        if (capture) begin
          overrun <= 1'b1;
        end
      end
      if (accept_start) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conversion_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conversion_sequencer
// Description : Self-checking bench for conversion_sequencer. A schedule-based
//               reference model (cycle offsets from the accepted start) is
//               compared against the DUT on every falling edge; directed
//               scenarios pin the model with literal expectations, followed
//               by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conversion_sequencer;

  localparam int OUTPUT_BITS = 16;
  localparam int OSR_BITS    = 8;
  localparam int DEC_M       = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic                   continuous = 1'b0;
  logic                   mode = 1'b0;
  logic [OSR_BITS-1:0]    osr = '0;
  logic [OUTPUT_BITS-1:0] filt_z = '0;
  logic                   filt_rst;
  logic                   filt_type;
  logic                   filt_greset;
  logic                   busy;
  logic [OUTPUT_BITS-1:0] result;
  logic                   result_valid;
  logic                   result_ready = 1'b0;
  logic                   overrun;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  conversion_sequencer #(
    .OUTPUT_BITS(OUTPUT_BITS),
    .OSR_BITS   (OSR_BITS),
    .DEC_M      (DEC_M)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .continuous  (continuous),
    .mode        (mode),
    .osr         (osr),
    .filt_z      (filt_z),
    .filt_rst    (filt_rst),
    .filt_type   (filt_type),
    .filt_greset (filt_greset),
    .busy        (busy),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Run timeline, counted in cycles after the accepted start edge:
  //   n = 1 : global clear
  //   incremental: conversion k starts at n = 2 + k*(L+2); dump at offset L,
  //                capture at the edge ending offset L+1
  //   regular    : capture at edges ending n-2 = j*DEC_M for j >= 2
  bit                     m_busy = 1'b0;
  bit                     m_mode = 1'b0;
  bit                     m_cont = 1'b0;
  bit                     m_valid = 1'b0;
  bit                     m_ovr = 1'b0;
  logic [OUTPUT_BITS-1:0] m_result = '0;
  int                     m_n = 0;
  int                     m_L = 2;
  bit                     m_cap;
  bit                     m_end;
  int                     m_p;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_mode = 0; m_cont = 0; m_valid = 0; m_ovr = 0;
      m_result = '0; m_n = 0; m_L = 2;
    end else begin
      m_cap = 0;
      m_end = 0;
      if (m_busy) begin
        if (stop) begin
          m_end = 1;
        end else begin
          m_p = m_n - 2;
          if (!m_mode) begin
            if (m_p >= 0 && (m_p % (m_L + 2)) == m_L + 1) begin
              m_cap = 1;
              m_end = !m_cont;
            end
          end else if (m_p >= 2 * DEC_M && (m_p % DEC_M) == 0) begin
            m_cap = 1;
          end
        end
        if (m_end) m_busy = 0;
        else m_n++;
      end else if (start && !stop) begin
        m_busy = 1;
        m_mode = mode;
        m_cont = continuous;
        m_L    = (osr < 2) ? 2 : int'(osr);
        m_n    = 1;
        m_ovr  = 0;
      end
      if (m_cap && (!m_valid || result_ready)) begin
        m_result = filt_z;
        m_valid  = 1;
      end else begin
        if (m_valid && result_ready) m_valid = 0;
        if (m_cap) m_ovr = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("filt_greset", filt_greset, (m_busy && m_n == 1));
      check("filt_rst", filt_rst,
            (m_busy && !m_mode && m_n >= 2 && ((m_n - 2) % (m_L + 2)) == m_L));
      check("filt_type", filt_type, m_mode);
      check("result_valid", result_valid, m_valid);
      check("result", result, m_result);
      check("overrun", overrun, m_ovr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    start = 0; stop = 0;
    result_ready = 1;
    tick; tick;
    result_ready = 0;
  endtask

  task automatic latency_test(input string name, input logic [7:0] osr_v, input int exp_cycle);
    int first_valid = -1;
    drain();
    mode = 0; continuous = 0; osr = osr_v; filt_z = 16'h5A3C;
    start = 1;            // cycle 0
    for (int n = 1; n <= exp_cycle + 3; n++) begin
      tick; start = 0;
      if (result_valid && first_valid < 0) first_valid = n;
    end
    check({name, "_valid_cycle"}, first_valid, exp_cycle);
    check({name, "_result"}, result, 16'h5A3C);
  endtask

  int first_valid, gr_cnt, gr_cycle, rst_cnt, rst_cycle, type_bad;
  logic busy_at20, prev_valid;
  int rise[$];

  initial begin
    repeat (3) tick;
    reset = 0;
    chk_en = 1;
    tick;

    // Basic incremental conversion, osr=16, one-shot.
    mode = 0; continuous = 0; osr = 16; filt_z = 16'h00A5; result_ready = 0;
    first_valid = -1; gr_cnt = 0; gr_cycle = -1; rst_cnt = 0; rst_cycle = -1;
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    start = 1;            // cycle 0
    for (int n = 1; n <= 24; n++) begin
      tick; start = 0;
      if (filt_greset) begin gr_cnt++; gr_cycle = n; end
      if (filt_rst) begin rst_cnt++; rst_cycle = n; end
      if (result_valid && first_valid < 0) first_valid = n;
      if (n == 20) busy_at20 = busy;
    end
    check("basic_greset_count", gr_cnt, 1);
    check("basic_greset_cycle", gr_cycle, 1);
    check("basic_rst_count", rst_cnt, 1);
    check("basic_rst_cycle", rst_cycle, 18);
    check("basic_valid_cycle", first_valid, 20);
    check("basic_result", result, 16'h00A5);
    check("basic_busy_after", busy_at20, 0);

    // Short osr values clamp to a 2-cycle conversion.
    latency_test("osr0", 8'd0, 6);
    latency_test("osr1", 8'd1, 6);

    // Continuous incremental with a stalled consumer.
    drain();
    mode = 0; continuous = 1; osr = 4; filt_z = 16'h1111;
    start = 1;
    for (int n = 1; n <= 16; n++) begin
      tick; start = 0;
      if (n == 8) begin
        check("ovr_first_valid", result_valid, 1);
        filt_z = 16'h2222;
      end
    end
    check("ovr_flag", overrun, 1);
    check("ovr_result_kept", result, 16'h1111);
    check("ovr_still_busy", busy, 1);
    stop = 1;
    tick; stop = 0;
    check("ovr_stop_idle", busy, 0);

    // Regular mode: captures every DEC_M cycles once settled.
    drain();
    result_ready = 1; mode = 1; continuous = 0; osr = 3;
    rst_cnt = 0; type_bad = 0; prev_valid = 0; rise.delete();
    start = 1;
    for (int n = 1; n <= 70; n++) begin
      tick; start = 0;
      filt_z = 16'($urandom);
      if (filt_rst) rst_cnt++;
      if (busy && !filt_type) type_bad++;
      if (result_valid && !prev_valid) rise.push_back(n);
      prev_valid = result_valid;
    end
    check("reg_rst_count", rst_cnt, 0);
    check("reg_type_bad", type_bad, 0);
    check("reg_capture_count", rise.size(), 3);
    if (rise.size() == 3) begin
      check("reg_capture0", rise[0], 35);
      check("reg_capture1", rise[1], 51);
      check("reg_capture2", rise[2], 67);
    end
    stop = 1;
    tick; stop = 0;
    check("reg_stop_idle", busy, 0);

    // Stop during DUMP, with a mode toggle mid-run.
    drain();
    mode = 0; continuous = 0; osr = 4;
    start = 1;
    for (int n = 1; n <= 6; n++) begin
      tick; start = 0;
      if (n == 3) mode = 1;
      if (n == 5) check("dump_type_held", filt_type, 0);
    end
    check("dump_rst_high", filt_rst, 1);
    stop = 1;
    tick; stop = 0;
    check("dump_stop_idle", busy, 0);
    check("dump_stop_valid", result_valid, 0);
    check("dump_stop_ovr", overrun, 0);
    check("dump_stop_type", filt_type, 0);
    tick;

    // Reset in the middle of a continuous run.
    drain();
    mode = 0; continuous = 1; osr = 4; filt_z = 16'h0F0F;
    start = 1;
    for (int n = 1; n <= 9; n++) begin
      tick; start = 0;
    end
    reset = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_type", filt_type, 0);
    check("rst_filt_rst", filt_rst, 0);
    tick;
    reset = 0;
    rst_cnt = 0;
    for (int n = 0; n < 30; n++) begin
      tick;
      if (filt_rst || busy) rst_cnt++;
    end
    check("rst_quiet", rst_cnt, 0);

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      tick;
      start        = ($urandom_range(0, 15) == 0);
      stop         = ($urandom_range(0, 79) == 0);
      mode         = 1'($urandom_range(0, 1));
      continuous   = 1'($urandom_range(0, 1));
      osr          = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                 : 8'($urandom_range(0, 6));
      result_ready = ($urandom_range(0, 2) != 0);
      filt_z       = 16'($urandom);
      reset        = ($urandom_range(0, 599) == 0);
    end
    reset = 0; start = 0; stop = 0;
    repeat (4) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
